// File: rtl/fpu_issue_ctrl_pkg.sv
// Package: fpu_issue_ctrl_pkg
// Shared definitions for the FP issue controller slice.
//  - op_class_t : decoded FP operation class (MOVE/ADD/MUL/DIV)
//  - DEF_LAT_*  : default issue->writeback latencies per class
//  - REG_W / NUM_REGS : FP register file index width and size
//  - lat_of()   : maps an op class to its issue->writeback latency
package fpu_issue_ctrl_pkg;

   localparam int DEF_LAT_ADD = 3;
   localparam int DEF_LAT_MUL = 3;
   localparam int DEF_LAT_DIV = 12;

   localparam int REG_W    = 5;
   localparam int NUM_REGS = 32;

   typedef enum logic [1:0] {
      OP_MOVE = 2'd0,
      OP_ADD  = 2'd1,
      OP_MUL  = 2'd2,
      OP_DIV  = 2'd3
   } op_class_t;

   // Latency of an op class; MOVE is a single-cycle register copy.
   function automatic int lat_of(op_class_t op, int lat_add, int lat_mul, int lat_div);
      case (op)
         OP_MOVE: return 1;
         OP_ADD:  return lat_add;
         OP_MUL:  return lat_mul;
         default: return lat_div;
      endcase
   endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Interface: fpu_issue_ctrl_if
// Bundles the decode-side request, the issue handshake and the
// writeback/status outputs of the FP issue controller.
//  master : FP decode side (drives the op, observes ready/fire/writeback)
//  slave  : the issue controller itself
interface fpu_issue_ctrl_if;
   import fpu_issue_ctrl_pkg::*;

   logic             id_valid;
   logic [1:0]       op_class;
   logic [REG_W-1:0] rs1i;
   logic [REG_W-1:0] rs2i;
   logic             use_rs1;
   logic             use_rs2;
   logic [REG_W-1:0] rdi;
   logic             is_regwrite;
   logic             flush;
   logic             issue_ready;
   logic             issue_fire;
   logic             wb_valid;
   logic [REG_W-1:0] wb_rdi;
   logic             div_busy;

   modport master (
      output id_valid, op_class, rs1i, rs2i, use_rs1, use_rs2, rdi, is_regwrite, flush,
      input  issue_ready, issue_fire, wb_valid, wb_rdi, div_busy
   );

   modport slave (
      input  id_valid, op_class, rs1i, rs2i, use_rs1, use_rs2, rdi, is_regwrite, flush,
      output issue_ready, issue_fire, wb_valid, wb_rdi, div_busy
   );

endinterface

// File: rtl/fpu_issue_ctrl_wb_reservation.sv
// Module: fpu_wb_reservation
// Writeback reservation window: a DEPTH-entry shift register of
// {valid, rdi}. Slot k holds the write that reaches the register file
// k-1 cycles after the current one, so slot 1 is the write happening now.
// Ports:
//  clk, rst     : clock, synchronous active-high reset
//  ins_valid    : reserve a slot this cycle
//  ins_offset   : slot (after this cycle's shift) to reserve, 1..DEPTH
//  ins_rdi      : destination register of the reservation
//  wb_valid/rdi : contents of slot 1 (current writeback)
//  pend         : per-register mask of valid writes in slots 2..DEPTH
//  slot_free    : slot_free[k]=1 when slot k is empty; bit DEPTH+1 is
//                 always free so a DEPTH-latency op never sees a conflict
module fpu_wb_reservation
   import fpu_issue_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_LAT_DIV,
   localparam int OFF_W = $clog2(DEPTH + 2)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ins_valid,
   input  logic [OFF_W-1:0]    ins_offset,
   input  logic [REG_W-1:0]    ins_rdi,
   output logic                wb_valid,
   output logic [REG_W-1:0]    wb_rdi,
   output logic [NUM_REGS-1:0] pend,
   output logic [DEPTH+1:1]    slot_free
);

   logic [DEPTH:1]   slot_vld;
   logic [REG_W-1:0] slot_rdi [DEPTH:1];

   // One-entry extension above the top slot so the shift reads an empty
   // entry into slot DEPTH without an out-of-range index.
   logic [DEPTH+1:1] vld_ext;
   logic [REG_W-1:0] rdi_ext [DEPTH+1:1];

   always_comb begin
      vld_ext = {1'b0, slot_vld};
      for (int k = 1; k <= DEPTH; k++) begin
         rdi_ext[k] = slot_rdi[k];
      end
      rdi_ext[DEPTH+1] = '0;
   end

   // Shift toward slot 1 every cycle and drop a new reservation into its
   // post-shift position. The issue logic guarantees that position is free,
   // so the insert never overwrites a shifted-in entry. Empty slots carry
   // rdi=0 so wb_rdi reads 0 whenever nothing is written.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_vld <= '0;
         for (int k = 1; k <= DEPTH; k++) begin
            slot_rdi[k] <= '0;
         end
      end else begin
         for (int k = 1; k <= DEPTH; k++) begin
            if (ins_valid && (ins_offset == OFF_W'(k))) begin
               slot_vld[k] <= 1'b1;
               slot_rdi[k] <= ins_rdi;
            end else begin
               slot_vld[k] <= vld_ext[k+1];
               slot_rdi[k] <= rdi_ext[k+1];
            end
         end
      end
   end

   // Registers with a write still in flight beyond the current writeback;
   // slot 1 is excluded because its value is forwarded from writeback.
   always_comb begin
      pend = '0;
      for (int k = 2; k <= DEPTH; k++) begin
         if (slot_vld[k]) begin
            pend[slot_rdi[k]] = 1'b1;
         end
      end
   end

   assign wb_valid  = slot_vld[1];
   assign wb_rdi    = slot_rdi[1];
   assign slot_free = {1'b1, ~slot_vld};

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Module: fpu_issue_ctrl
// In-order issue controller for the FPU pipeline. Each cycle it decides
// whether the op in FP decode may issue, checking RAW/WAW hazards against
// pending writes, the single writeback port and the non-pipelined
// div/sqrt unit, and it drives the FP register file writeback.
// Ports:
//  clk, rst : clock, synchronous active-high reset
//  bus      : fpu_issue_ctrl_if.slave (decode request, issue_ready,
//             issue_fire, wb_valid, wb_rdi, div_busy)
// LAT_DIV must be at least max(LAT_ADD, LAT_MUL): the reservation window
// is LAT_DIV slots deep and every latency must fit inside it.
module fpu_issue_ctrl
   import fpu_issue_ctrl_pkg::*;
#(
   parameter int LAT_ADD = DEF_LAT_ADD,
   parameter int LAT_MUL = DEF_LAT_MUL,
   parameter int LAT_DIV = DEF_LAT_DIV
) (
   input logic             clk,
   input logic             rst,
   fpu_issue_ctrl_if.slave bus
);

   localparam int WB_DEPTH = LAT_DIV;
   localparam int OFF_W    = $clog2(WB_DEPTH + 2);
   localparam int CNT_W    = $clog2(LAT_DIV + 1);

   op_class_t          op;
   int                 lat;
   logic [OFF_W-1:0]   ins_offset;
   logic [OFF_W-1:0]   port_idx;
   logic               wb_valid;
   logic [REG_W-1:0]   wb_rdi;
   logic [NUM_REGS-1:0] pend;
   logic [WB_DEPTH+1:1] slot_free;
   logic [CNT_W-1:0]   div_cnt;
   logic               div_busy;
   logic               raw_hz;
   logic               waw_hz;
   logic               port_hz;
   logic               div_hz;
   logic               issue_ready;
   logic               issue_fire;

   assign op = op_class_t'(bus.op_class);

   // The new result lands in slot L after the shift, which is slot L+1 now.
   always_comb begin
      lat        = lat_of(op, LAT_ADD, LAT_MUL, LAT_DIV);
      ins_offset = OFF_W'(lat);
      port_idx   = OFF_W'(lat + 1);
   end

   // Hazard checks. A source being written this cycle is not a RAW hazard
   // because execute forwards it from writeback, but a destination matching
   // even the current writeback still blocks to keep write order simple.
   always_comb begin
      raw_hz  = (bus.use_rs1 & pend[bus.rs1i]) | (bus.use_rs2 & pend[bus.rs2i]);
      waw_hz  = bus.is_regwrite & (pend[bus.rdi] | (wb_valid & (wb_rdi == bus.rdi)));
      port_hz = bus.is_regwrite & ~slot_free[port_idx];
      div_hz  = (op == OP_DIV) & div_busy;
      issue_ready = ~(raw_hz | waw_hz | port_hz | div_hz);
      issue_fire  = bus.id_valid & issue_ready & ~bus.flush;
   end

   fpu_wb_reservation #(
      .DEPTH (WB_DEPTH)
   ) u_resv (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (issue_fire & bus.is_regwrite),
      .ins_offset (ins_offset),
      .ins_rdi    (bus.rdi),
      .wb_valid   (wb_valid),
      .wb_rdi     (wb_rdi),
      .pend       (pend),
      .slot_free  (slot_free)
   );

   // Div/sqrt occupancy: loaded with LAT_DIV on issue so the unit reads busy
   // through its writeback cycle and frees up on the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (issue_fire && (op == OP_DIV)) begin
         div_cnt <= CNT_W'(LAT_DIV);
      end else if (div_cnt != '0) begin
         div_cnt <= div_cnt - CNT_W'(1);
      end
   end

   assign div_busy = (div_cnt != '0);

   assign bus.issue_ready = issue_ready;
   assign bus.issue_fire  = issue_fire;
   assign bus.wb_valid    = wb_valid;
   assign bus.wb_rdi      = wb_rdi;
   assign bus.div_busy    = div_busy;

endmodule
